// File: rtl/nibble_serial_adder_ctrl_if.sv
// Operand/result bundle for nibble_serial_adder_ctrl.
// Optional macro SUB_EN adds the sub (A-B) request line.
interface nibble_serial_adder_ctrl_if #(
   parameter int unsigned N_NIB = 4
);
   logic                 start;
   logic [4*N_NIB-1:0]   a;
   logic [4*N_NIB-1:0]   b;
`ifdef SUB_EN
   logic                 sub;
`endif
   logic                 busy;
   logic                 done;
   logic [4*N_NIB-1:0]   s;
   logic                 c_out;
   logic                 v;

   modport master (
      output start, a, b,
`ifdef SUB_EN
      output sub,
`endif
      input  busy, done, s, c_out, v
   );

   modport slave (
      input  start, a, b,
`ifdef SUB_EN
      input  sub,
`endif
      output busy, done, s, c_out, v
   );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial adder: one 4-bit ripple slice reused over N_NIB cycles per operation.
// Optional macro SUB_EN enables A-B via inverted B and carry-in of 1.
module nibble_serial_adder_ctrl #(
   parameter int unsigned N_NIB = 4
) (
   input logic                       clk,
   input logic                       rst,
   nibble_serial_adder_ctrl_if.slave bus
);
   localparam int unsigned W  = 4 * N_NIB;
   localparam int unsigned IW = $clog2(N_NIB);
   localparam logic [IW-1:0] LastIdx = IW'(N_NIB - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e        state_q;
   logic [W-1:0]  a_q;
   logic [W-1:0]  b_q;
   logic [W-1:0]  s_q;
   logic [IW-1:0] idx_q;
   logic          carry_q;
   logic          c_out_q;
   logic          v_q;
   logic          done_q;

   logic          b_inv;
   logic [3:0]    nib_a;
   logic [3:0]    nib_b;
   logic [3:0]    nib_s;
   logic          c1, c2, c3, c4;
   logic          s0, s1, s2, s3;

`ifdef SUB_EN
   assign b_inv = bus.sub;
`else
   assign b_inv = 1'b0;
`endif

   function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
      return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
   endfunction

   assign nib_a = a_q[{idx_q, 2'b00} +: 4];
   assign nib_b = b_q[{idx_q, 2'b00} +: 4];

   // The single shared 4-bit ripple slice.
   assign {c1, s0} = full_add(nib_a[0], nib_b[0], carry_q);
   assign {c2, s1} = full_add(nib_a[1], nib_b[1], c1);
   assign {c3, s2} = full_add(nib_a[2], nib_b[2], c2);
   assign {c4, s3} = full_add(nib_a[3], nib_b[3], c3);
   assign nib_s    = {s3, s2, s1, s0};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         c_out_q <= 1'b0;
         v_q     <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (bus.start) begin
                  a_q     <= bus.a;
                  b_q     <= b_inv ? ~bus.b : bus.b;
                  carry_q <= b_inv;
                  idx_q   <= '0;
                  state_q <= StRun;
               end
            end
            StRun: begin
               s_q[{idx_q, 2'b00} +: 4] <= nib_s;
               carry_q <= c4;
               idx_q   <= idx_q + 1'b1;
               if (idx_q == LastIdx) state_q <= StDone;
            end
            StDone: begin
               done_q  <= 1'b1;
               c_out_q <= carry_q;
               v_q     <= (a_q[W-1] == b_q[W-1]) && (s_q[W-1] != a_q[W-1]);
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.busy  = (state_q != StIdle);
   assign bus.done  = done_q;
   assign bus.s     = s_q;
   assign bus.c_out = c_out_q;
   assign bus.v     = v_q;
endmodule
